mil_receiver: RTL and testbench

MIL_RECEIVER -- requirements
Module: mil_receiver

---
 rtl/mil_receiver.sv | 260 ++++++++++++++++++++++++++
 tb/tb_mil_receiver.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mil_receiver.sv
// mil_receiver
//    MIL-STD-1553 Manchester word receiver. Synchronizes both legs of the
//    differential line, locks onto a sync pattern, samples sixteen data bits
//    plus an odd parity bit and hands the word to a consumer. The consumer
//    side uses a valid/ack handshake with a sticky overrun flag.
//
// Ports
//    clk         system clock, all logic on its rising edge
//    nRst        synchronous active-low reset
//    RXin        MIL line positive leg (asynchronous)
//    nRXin       MIL line negative leg (asynchronous)
//    rx_data     received word, bit 15 received first
//    rx_type     WDATA / WSERV / WDATAERR / WSERVERR
//    rx_valid    rx_data/rx_type hold an unacknowledged word
//    rx_ack      consumer accepts the held word
//    rx_overrun  sticky: a word was dropped because the previous one was held
//    busy        decoder is inside a word
//
// state | meaning
// IDLE  | measuring run lengths, waiting for a mid-sync edge
// SYNC2 | inside the second half of the sync pattern
// DATA  | sampling data bits 0..15 and the parity bit
// POST  | word delivered, watching for the end of parity or a back-to-back sync

module mil_receiver #(
    parameter int HALF_BIT = 8
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        RXin,
    input  logic        nRXin,
    output logic [15:0] rx_data,
    output logic [1:0]  rx_type,
    output logic        rx_valid,
    input  logic        rx_ack,
    output logic        rx_overrun,
    output logic        busy
);

    localparam int TOL = HALF_BIT / 2;

    localparam logic [1:0] WDATA    = 2'b00;
    localparam logic [1:0] WSERV    = 2'b01;
    localparam logic [1:0] WDATAERR = 2'b10;
    localparam logic [1:0] WSERVERR = 2'b11;

    localparam logic [7:0] SYNC_MIN   = 8'(3 * HALF_BIT - TOL);
    localparam logic [7:0] SYNC_MAX   = 8'(3 * HALF_BIT + TOL);
    localparam logic [7:0] SYNC_END   = 8'(3 * HALF_BIT - 1);
    localparam logic [7:0] S1_PH      = 8'(TOL);
    localparam logic [7:0] S2_PH      = 8'(TOL + HALF_BIT);
    localparam logic [7:0] BIT_END    = 8'(2 * HALF_BIT - 1);
    localparam logic [7:0] POST_ENTRY = 8'(TOL + 1);
    localparam logic [7:0] GAP_MIN    = 8'(HALF_BIT - TOL);
    localparam logic [7:0] GAP_MAX    = 8'(HALF_BIT + TOL);
    localparam logic [7:0] NEXT_MIN   = 8'(4 * HALF_BIT - TOL);
    localparam logic [7:0] NEXT_MAX   = 8'(4 * HALF_BIT + TOL);
    localparam logic [4:0] PAR_IDX    = 5'd16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC2 = 2'd1,
        DATA  = 2'd2,
        POST  = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n, cnt_inc;
    logic [4:0]  bit_idx, bit_n;
    logic        serv, serv_n;

    logic        rx_m, rx_s, nrx_m, nrx_s, line_prev;
    logic        line, line_ok, line_edge;

    logic [15:0] shreg;
    logic        s1_val, s1_ok, err_acc, par_acc;

    logic        s1_hit, s2_hit, deliver, bit_err, word_err, sync_start;

    // ------------------------------------------------------------------
    // Line synchronizers and edge detect
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nRst) begin
            rx_m      <= 1'b0;
            rx_s      <= 1'b0;
            nrx_m     <= 1'b0;
            nrx_s     <= 1'b0;
            line_prev <= 1'b0;
        end else begin
            rx_m      <= RXin;
            rx_s      <= rx_m;
            nrx_m     <= nRXin;
            nrx_s     <= nrx_m;
            line_prev <= rx_s;
        end
    end

    assign line      = rx_s;
    assign line_ok   = rx_s ^ nrx_s;
    assign line_edge = rx_s ^ line_prev;
    assign cnt_inc   = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            bit_idx <= 5'd0;
            serv    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            serv    <= serv_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // cnt holds the run length in IDLE, time since the mid-sync edge in
    // SYNC2, phase within the current bit in DATA and time since the parity
    // mid-bit edge in POST. An edge that restarts a run sets it to 1 so that
    // the value seen at the following edge is the true run length.
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state;
        cnt_n   = cnt_inc;
        bit_n   = bit_idx;
        serv_n  = serv;
        unique case (state)
            IDLE: begin
                if (!line_ok) begin
                    cnt_n = 8'd0;
                end else if (line_edge) begin
                    cnt_n = 8'd1;
                    if (cnt >= SYNC_MIN && cnt <= SYNC_MAX) begin
                        state_n = SYNC2;
                        serv_n  = line_prev;
                    end
                end
            end
            SYNC2: begin
                if ((line_edge || !line_ok) && cnt < SYNC_MIN) begin
                    state_n = IDLE;
                    cnt_n   = line_ok ? 8'd1 : 8'd0;
                end else if (cnt == SYNC_END) begin
                    state_n = DATA;
                    cnt_n   = 8'd0;
                    bit_n   = 5'd0;
                end
            end
            DATA: begin
                if (bit_idx == PAR_IDX && cnt == S2_PH) begin
                    state_n = POST;
                    cnt_n   = POST_ENTRY;
                end else if (cnt == BIT_END) begin
                    cnt_n = 8'd0;
                    bit_n = bit_idx + 5'd1;
                end
            end
            POST: begin
                if (!line_ok) begin
                    state_n = IDLE;
                    cnt_n   = 8'd0;
                end else if (line_edge) begin
                    if (cnt >= GAP_MIN && cnt <= GAP_MAX) begin
                        // end of the parity bit: the next sync run starts here
                        state_n = IDLE;
                        cnt_n   = 8'd0;
                    end else if (cnt >= NEXT_MIN && cnt <= NEXT_MAX) begin
                        // parity second half merged with the next sync first half
                        state_n = SYNC2;
                        cnt_n   = 8'd1;
                        serv_n  = line_prev;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = 8'd1;
                    end
                end else if (cnt > NEXT_MAX) begin
                    // no edge since the parity mid-bit, so cnt is still the run
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 8'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / strobe logic
    // ------------------------------------------------------------------
    always_comb begin
        busy       = (state != IDLE);
        sync_start = (state_n == SYNC2) && (state != SYNC2);
        s1_hit     = (state == DATA) && (cnt == S1_PH);
        s2_hit     = (state == DATA) && (cnt == S2_PH);
        deliver    = s2_hit && (bit_idx == PAR_IDX);
        bit_err    = (s1_val == line) || !s1_ok || !line_ok;
        // par_acc already includes the parity bit; odd total means good
        word_err   = err_acc || bit_err || !par_acc;
    end

    // ------------------------------------------------------------------
    // Bit sampling datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nRst) begin
            shreg   <= 16'h0000;
            s1_val  <= 1'b0;
            s1_ok   <= 1'b0;
            err_acc <= 1'b0;
            par_acc <= 1'b0;
        end else if (sync_start) begin
            shreg   <= 16'h0000;
            err_acc <= 1'b0;
            par_acc <= 1'b0;
        end else begin
            if (s1_hit) begin
                s1_val  <= line;
                s1_ok   <= line_ok;
                par_acc <= par_acc ^ line;
                if (bit_idx != PAR_IDX) begin
                    shreg <= {shreg[14:0], line};
                end
            end
            if (s2_hit) begin
                err_acc <= err_acc | bit_err;
            end
        end
    end

    // ------------------------------------------------------------------
    // Consumer handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nRst) begin
            rx_data    <= 16'h0000;
            rx_type    <= WDATA;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else if (deliver) begin
            if (!rx_valid || rx_ack) begin
                rx_data  <= shreg;
                rx_type  <= word_err ? (serv ? WSERVERR : WDATAERR)
                                     : (serv ? WSERV    : WDATA);
                rx_valid <= 1'b1;
            end else begin
                rx_overrun <= 1'b1;
            end
        end else if (rx_ack) begin
            rx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mil_receiver.sv
// tb_mil_receiver
//    Directed bench for mil_receiver at HALF_BIT=8. Words are driven as
//    Manchester waveforms; expected data, type and timing are hand-derived.

module tb_mil_receiver;

    localparam int HB  = 8;
    localparam int TOL = HB / 2;

    localparam logic [1:0] WDATA    = 2'b00;
    localparam logic [1:0] WSERV    = 2'b01;
    localparam logic [1:0] WDATAERR = 2'b10;
    localparam logic [1:0] WSERVERR = 2'b11;

    logic        clk;
    logic        nRst;
    logic        RXin;
    logic        nRXin;
    logic [15:0] rx_data;
    logic [1:0]  rx_type;
    logic        rx_valid;
    logic        rx_ack;
    logic        rx_overrun;
    logic        busy;

    int total;
    int bad;
    int cyc;
    int sync_cyc;
    int rise_cyc;
    logic valid_q;
    logic busy_seen;
    logic valid_seen;

    mil_receiver #(.HALF_BIT(HB)) dut (
        .clk        (clk),
        .nRst       (nRst),
        .RXin       (RXin),
        .nRXin      (nRXin),
        .rx_data    (rx_data),
        .rx_type    (rx_type),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .rx_overrun (rx_overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        valid_q    = 1'b0;
        busy_seen  = 1'b0;
        valid_seen = 1'b0;
        rise_cyc   = -1;
    end

    always @(negedge clk) begin
        if (busy) busy_seen = 1'b1;
        if (rx_valid) valid_seen = 1'b1;
        if (rx_valid && !valid_q) rise_cyc = cyc;
        valid_q = rx_valid;
    end

    // All drive tasks start and end #1 after a rising edge.
    task automatic drive(input logic lvl, input int n);
        RXin  = lvl;
        nRXin = !lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic line_idle(input int n);
        RXin  = 1'b0;
        nRXin = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // flat_k: bit position held high for a whole bit; stop_k: bit after
    // whose first half the word is abandoned (17 = send complete word).
    task automatic send_word(input logic serv, input logic [15:0] d,
                             input logic par, input int flat_k, input int stop_k);
        logic b;
        drive(serv, 3 * HB);
        sync_cyc = cyc;
        drive(!serv, 3 * HB);
        for (int k = 0; k < 17; k++) begin
            b = (k < 16) ? d[15 - k] : par;
            if (k == stop_k) begin
                drive(b, HB);
                return;
            end
            if (k == flat_k) begin
                drive(1'b1, 2 * HB);
            end else begin
                drive(b, HB);
                drive(!b, HB);
            end
        end
    endtask

    task automatic ack_word();
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (rx_data !== 16'h0000) begin bad++; $display("FAIL reset_data: got %h want 0000", rx_data); end
        total++; if (rx_type !== WDATA) begin bad++; $display("FAIL reset_type: got %b want %b", rx_type, WDATA); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", rx_overrun); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    // 0xA5C3 holds eight ones, so its odd-parity bit is 1.
    task automatic test_basic();
        rise_cyc = -1;
        send_word(1'b0, 16'hA5C3, 1'b1, -1, 17);
        line_idle(40);
        // 2 synchronizer flops + edge register + 36 half-bits + TOL
        total++; if (rise_cyc - sync_cyc !== 3 + 36 * HB + TOL) begin
            bad++; $display("FAIL basic_latency: got %0d want %0d", rise_cyc - sync_cyc, 3 + 36 * HB + TOL);
        end
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", rx_valid); end
        total++; if (rx_data !== 16'hA5C3) begin bad++; $display("FAIL basic_data: got %h want a5c3", rx_data); end
        total++; if (rx_type !== WDATA) begin bad++; $display("FAIL basic_type: got %b want %b", rx_type, WDATA); end
        ack_word();
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL basic_ack_clear: got %b want 0", rx_valid); end
    endtask

    task automatic test_serv();
        send_word(1'b1, 16'h0000, 1'b0, -1, 17);
        line_idle(40);
        total++; if (rx_data !== 16'h0000) begin bad++; $display("FAIL serv_par0_data: got %h want 0000", rx_data); end
        total++; if (rx_type !== WSERVERR) begin bad++; $display("FAIL serv_par0_type: got %b want %b", rx_type, WSERVERR); end
        ack_word();
        send_word(1'b1, 16'h0000, 1'b1, -1, 17);
        line_idle(40);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL serv_par1_valid: got %b want 1", rx_valid); end
        total++; if (rx_type !== WSERV) begin bad++; $display("FAIL serv_par1_type: got %b want %b", rx_type, WSERV); end
        ack_word();
    endtask

    // data bit 7 is bit position 8 on the line
    task automatic test_manchester_err();
        send_word(1'b0, 16'h0080, 1'b0, 8, 17);
        line_idle(40);
        total++; if (rx_type !== WDATAERR) begin bad++; $display("FAIL manch_type: got %b want %b", rx_type, WDATAERR); end
        total++; if (rx_data !== 16'h0080) begin bad++; $display("FAIL manch_data: got %h want 0080", rx_data); end
        ack_word();
    endtask

    task automatic test_short_sync();
        busy_seen  = 1'b0;
        valid_seen = 1'b0;
        drive(1'b0, 2 * HB);
        drive(1'b1, 2 * HB);
        line_idle(60);
        total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL short_sync_busy: got %b want 0", busy_seen); end
        total++; if (valid_seen !== 1'b0) begin bad++; $display("FAIL short_sync_valid: got %b want 0", valid_seen); end
    endtask

    // Third word exercises the merged parity/sync path (0xFFFF parity ends low).
    task automatic test_back_to_back_ack();
        logic [15:0] got_d [3];
        logic [1:0]  got_t [3];
        logic [15:0] exp_d [3];
        exp_d[0] = 16'h1234;
        exp_d[1] = 16'hFFFF;
        exp_d[2] = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            got_d[i] = 16'hxxxx;
            got_t[i] = 2'bxx;
        end
        fork
            begin
                send_word(1'b0, 16'h1234, 1'b0, -1, 17);
                send_word(1'b0, 16'hFFFF, 1'b1, -1, 17);
                send_word(1'b0, 16'h5555, 1'b1, -1, 17);
                line_idle(40);
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    int n;
                    n = 0;
                    while (!rx_valid && n < 3000) begin
                        @(negedge clk);
                        n++;
                    end
                    if (!rx_valid) begin
                        total++; bad++;
                        $display("FAIL b2b_timeout: word %0d got no rx_valid want 1", i);
                    end
                    got_d[i] = rx_data;
                    got_t[i] = rx_type;
                    rx_ack = 1'b1;
                    @(posedge clk);
                    #1;
                    rx_ack = 1'b0;
                end
            end
        join
        for (int i = 0; i < 3; i++) begin
            total++; if (got_d[i] !== exp_d[i]) begin bad++; $display("FAIL b2b_data%0d: got %h want %h", i, got_d[i], exp_d[i]); end
            total++; if (got_t[i] !== WDATA) begin bad++; $display("FAIL b2b_type%0d: got %b want %b", i, got_t[i], WDATA); end
        end
        total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun: got %b want 0", rx_overrun); end
    endtask

    task automatic test_overrun();
        send_word(1'b0, 16'h1234, 1'b0, -1, 17);
        send_word(1'b0, 16'hFFFF, 1'b1, -1, 17);
        line_idle(40);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid: got %b want 1", rx_valid); end
        total++; if (rx_data !== 16'h1234) begin bad++; $display("FAIL ovr_data: got %h want 1234", rx_data); end
        total++; if (rx_type !== WDATA) begin bad++; $display("FAIL ovr_type: got %b want %b", rx_type, WDATA); end
        total++; if (rx_overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %b want 1", rx_overrun); end
    endtask

    task automatic test_reset_mid_word();
        send_word(1'b0, 16'h00FF, 1'b1, -1, 8);
        nRst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", rx_valid); end
        line_idle(2);
        nRst       = 1'b1;
        busy_seen  = 1'b0;
        valid_seen = 1'b0;
        line_idle(400);
        total++; if (valid_seen !== 1'b0) begin bad++; $display("FAIL midrst_no_delivery: got %b want 0", valid_seen); end
        total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL midrst_busy_after: got %b want 0", busy_seen); end
        total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL midrst_overrun: got %b want 0", rx_overrun); end
        send_word(1'b0, 16'h00FF, 1'b1, -1, 17);
        line_idle(40);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL midrst_word_valid: got %b want 1", rx_valid); end
        total++; if (rx_data !== 16'h00FF) begin bad++; $display("FAIL midrst_word_data: got %h want 00ff", rx_data); end
        total++; if (rx_type !== WDATA) begin bad++; $display("FAIL midrst_word_type: got %b want %b", rx_type, WDATA); end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        RXin   = 1'b0;
        nRXin  = 1'b0;
        rx_ack = 1'b0;
        nRst   = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        test_reset();
        nRst = 1'b1;
        line_idle(10);
        test_basic();
        test_serv();
        test_manchester_err();
        test_short_sync();
        test_back_to_back_ack();
        test_overrun();
        test_reset_mid_word();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
